maze_port_arbiter: RTL and testbench

- Shares the single maze memory port between NUM_REQ independent maze walkers. The port is row/col select, maze_oe, maze_we and maze_in.
- Arbitration is round-robin. Each granted request becomes one registered memory access, returned to its requester with a one-cycle ack pulse.
- Out-of-range coordinates are screened so walkers never address outside the maze.
- Sits between the walker FSMs and the maze storage.

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_port_arbiter_rr_pick.sv | 32 +++
 rtl/maze_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_maze_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: arbiter state encoding, cell values and default maze geometry.
// Walkers and the port arbiter both import this package.
package maze_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    localparam logic MAZE_WALL = 1'b1;
    localparam logic MAZE_FREE = 1'b0;

    localparam int MAZE_WIDTH_DEF = 6;
    localparam int MAZE_DIM_DEF   = 64;

endpackage

// File: rtl/maze_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
// Assumes ptr < NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win,
    output logic               vld
);

    logic [ID_W:0] cand;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        win  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (req[cand[ID_W-1:0]]) begin
                win = cand[ID_W-1:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing the single maze memory port among NUM_REQ walkers.
// Each grant runs ARB -> ISSUE -> ACK; out-of-range coordinates never reach the port.
module maze_port_arbiter
    import maze_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int MAZE_DIM   = MAZE_DIM_DEF,
    parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*maze_width-1:0]   req_row,
    input  logic [NUM_REQ*maze_width-1:0]   req_col,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            rsp_data,
    output logic                            rsp_err,
    output logic [REQ_ID_W-1:0]             grant_id,
    output logic                            busy,
    output logic [maze_width-1:0]           row,
    output logic [maze_width-1:0]           col,
    output logic                            maze_oe,
    output logic                            maze_we,
    input  logic                            maze_in
);

    localparam logic [maze_width:0]   DIM_L   = (maze_width + 1)'(MAZE_DIM);
    localparam logic [REQ_ID_W-1:0]   LAST_ID = REQ_ID_W'(NUM_REQ - 1);

    arb_state_e state_q, state_d;

    logic [REQ_ID_W-1:0]   ptr_q, ptr_d;
    logic [REQ_ID_W-1:0]   gid_q, gid_d;
    logic [maze_width-1:0] row_q, row_d;
    logic [maze_width-1:0] col_q, col_d;
    logic                  we_lat_q, we_lat_d;
    logic                  oob_q, oob_d;
    logic                  oe_q, oe_d;
    logic                  mwe_q, mwe_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rd_pass_q, rd_pass_d;
    logic                  busy_q, busy_d;

    logic [REQ_ID_W-1:0]   win;
    logic                  win_vld;
    logic [maze_width-1:0] sel_row;
    logic [maze_width-1:0] sel_col;
    logic                  sel_we;
    logic                  sel_oob;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .vld (win_vld)
    );

    always_comb begin
        sel_row = '0;
        sel_col = '0;
        sel_we  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == REQ_ID_W'(k)) begin
                sel_row = req_row[k*maze_width +: maze_width];
                sel_col = req_col[k*maze_width +: maze_width];
                sel_we  = req_we[k];
            end
        end
        sel_oob = ({1'b0, sel_row} >= DIM_L) || ({1'b0, sel_col} >= DIM_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            gid_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            we_lat_q   <= 1'b0;
            oob_q      <= 1'b0;
            oe_q       <= 1'b0;
            mwe_q      <= 1'b0;
            ack_q      <= '0;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rd_pass_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            row_q      <= row_d;
            col_q      <= col_d;
            we_lat_q   <= we_lat_d;
            oob_q      <= oob_d;
            oe_q       <= oe_d;
            mwe_q      <= mwe_d;
            ack_q      <= ack_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rd_pass_q  <= rd_pass_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (win_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // Output registers are loaded one state ahead so they are visible during the state itself.
    always_comb begin
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        row_d      = row_q;
        col_d      = col_q;
        we_lat_d   = we_lat_q;
        oob_d      = oob_q;
        oe_d       = 1'b0;
        mwe_d      = 1'b0;
        ack_d      = '0;
        rsp_data_d = MAZE_FREE;
        rsp_err_d  = 1'b0;
        rd_pass_d  = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_ARB: begin
                if (win_vld) begin
                    gid_d    = win;
                    row_d    = sel_row;
                    col_d    = sel_col;
                    we_lat_d = sel_we;
                    oob_d    = sel_oob;
                    ptr_d    = (win == LAST_ID) ? '0 : win + 1'b1;
                    oe_d     = ~sel_we & ~sel_oob;
                    mwe_d    = sel_we & ~sel_oob;
                    busy_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                ack_d[gid_q] = 1'b1;
                busy_d       = 1'b1;
                if (oob_q) begin
                    rsp_data_d = MAZE_WALL;
                    rsp_err_d  = 1'b1;
                end else if (!we_lat_q) begin
                    rd_pass_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // maze_in only becomes valid during ACK, so a read returns it through a registered select.
    assign rsp_data = rd_pass_q ? maze_in : rsp_data_q;
    assign ack      = ack_q;
    assign rsp_err  = rsp_err_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign row      = row_q;
    assign col      = col_q;
    assign maze_oe  = oe_q;
    assign maze_we  = mwe_q;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with a transaction-level model checked every cycle.
module tb_maze_port_arbiter;

    localparam int MW = 6;
    localparam int NR = 4;
    localparam int MD = 40;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*MW-1:0]  req_row = '0;
    logic [NR*MW-1:0]  req_col = '0;
    logic [NR-1:0]     ack;
    logic              rsp_data;
    logic              rsp_err;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [MW-1:0]     row;
    logic [MW-1:0]     col;
    logic              maze_oe;
    logic              maze_we;
    logic              maze_in = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    maze_port_arbiter #(
        .maze_width (MW),
        .NUM_REQ    (NR),
        .MAZE_DIM   (MD),
        .REQ_ID_W   (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_row  (req_row),
        .req_col  (req_col),
        .ack      (ack),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .grant_id (grant_id),
        .busy     (busy),
        .row      (row),
        .col      (col),
        .maze_oe  (maze_oe),
        .maze_we  (maze_we),
        .maze_in  (maze_in)
    );

    always #5 clk = ~clk;

    function automatic logic wall(int r, int c);
        return ((r + c) % 3) == 0;
    endfunction

    // Synchronous maze storage; when not read it shows the inverted cell to expose mistimed sampling.
    always @(posedge clk) begin
        maze_in <= maze_oe ? wall(int'(row), int'(col)) : ~wall(int'(row), int'(col));
        cyc     <= cyc + 1;
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(logic [NR-1:0] r, int p);
        for (int i = 0; i < NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    // Model: each grant schedules an issue cycle, an ack cycle and one idle arbitration cycle.
    bit            mvalid = 0;
    int            m_ptr = 0, m_pend = 0, m_g = 0, m_row = 0, m_col = 0;
    logic          m_we = 0, m_oob = 0;
    logic [NR-1:0] e_ack = '0;
    bit            e_oe = 0, e_we = 0, e_busy = 0, e_rd = 0, e_err = 0, e_addr = 0, e_rstd = 0;
    int            e_row = 0, e_col = 0, e_gid = 0;

    initial forever begin
        int g;
        @(posedge clk);
        e_rstd = 0;
        e_ack  = '0;
        e_oe   = 0;
        e_we   = 0;
        e_rd   = 0;
        e_err  = 0;
        if (rst) begin
            mvalid = 1;
            m_ptr  = 0;
            m_pend = 0;
            e_rstd = 1;
            e_busy = 0;
            e_addr = 1;
            e_row  = 0;
            e_col  = 0;
            e_gid  = 0;
        end else if (m_pend == 2) begin
            m_pend     = 1;
            e_busy     = 1;
            e_addr     = 1;
            e_ack[m_g] = 1'b1;
            e_err      = m_oob;
            e_rd       = m_oob ? 1'b1 : (m_we ? 1'b0 : wall(m_row, m_col));
        end else if (m_pend == 1) begin
            m_pend = 0;
            e_busy = 0;
            e_addr = 0;
        end else begin
            g = pick(req, m_ptr);
            if (g >= 0) begin
                m_g    = g;
                m_row  = int'(req_row[g*MW +: MW]);
                m_col  = int'(req_col[g*MW +: MW]);
                m_we   = req_we[g];
                m_oob  = (m_row >= MD) || (m_col >= MD);
                m_ptr  = (g + 1) % NR;
                m_pend = 2;
                e_busy = 1;
                e_addr = 1;
                e_row  = m_row;
                e_col  = m_col;
                e_gid  = g;
                e_oe   = !m_we && !m_oob;
                e_we   = m_we && !m_oob;
            end else begin
                e_busy = 0;
                e_addr = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            chk("ack", int'(ack), int'(e_ack));
            chk("maze_oe", int'(maze_oe), int'(e_oe));
            chk("maze_we", int'(maze_we), int'(e_we));
            chk("busy", int'(busy), int'(e_busy));
            chk("oe_we_excl", int'(maze_oe & maze_we), 0);
            if (e_addr) begin
                chk("row", int'(row), e_row);
                chk("col", int'(col), e_col);
                chk("grant_id", int'(grant_id), e_gid);
            end
            if (e_ack != '0 || e_rstd) begin
                chk("rsp_data", int'(rsp_data), int'(e_rd));
                chk("rsp_err", int'(rsp_err), int'(e_err));
            end
        end
    end

    task automatic set_req(int k, logic we, int r, int c);
        req_we[k]           = we;
        req_row[k*MW +: MW] = MW'(r);
        req_col[k*MW +: MW] = MW'(c);
    endtask

    task automatic wait_ack(output logic [NR-1:0] a, output int at);
        a  = '0;
        at = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                a  = ack;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        logic [NR-1:0] a;
        int at, prev, start;
        bit seen;
        int order[5] = '{0, 1, 2, 3, 0};
        int tr[6]    = '{45, 40, 39,  0, 38, 0};
        int tc[6]    = '{ 3,  0,  0, 40,  0, 0};
        int te[6]    = '{ 1,  1,  0,  1,  0, 0};
        int td[6]    = '{ 1,  1,  1,  1,  0, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ack", int'(ack), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_gid", int'(grant_id), 0);

        // Single read of a wall cell
        set_req(1, 1'b0, 5, 7);
        req = 4'b0010;
        @(negedge clk);
        chk("read_oe", int'(maze_oe), 1);
        chk("read_row", int'(row), 5);
        chk("read_col", int'(col), 7);
        @(negedge clk);
        chk("read_ack", int'(ack), 4'b0010);
        chk("read_data", int'(rsp_data), 1);
        chk("read_err", int'(rsp_err), 0);
        req = '0;

        // Fairness from pointer 0 with all four requesting
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, k * 3 + 1, k + 2);
        req  = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, at);
            chk("rr_order", int'(a), 1 << order[k]);
            if (k > 0) chk("rr_spacing", at - prev, 3);
            prev = at;
        end
        req = '0;

        // Pointer skip and wrap
        set_req(2, 1'b0, 20, 21);
        req = 4'b0100;
        wait_ack(a, at);
        chk("ptr_to3", int'(a), 4'b0100);
        set_req(0, 1'b0, 2, 2);
        req = 4'b0101;
        wait_ack(a, at);
        chk("wrap_first", int'(a), 4'b0001);
        req = 4'b0100;
        wait_ack(a, at);
        chk("wrap_second", int'(a), 4'b0100);
        set_req(3, 1'b0, 9, 9);
        req = 4'b1000;
        wait_ack(a, at);
        chk("grant3", int'(a), 4'b1000);
        set_req(1, 1'b0, 1, 1);
        req = 4'b0011;
        wait_ack(a, at);
        chk("ptr_back0", int'(a), 4'b0001);
        req = '0;

        // Write on a boundary column
        set_req(2, 1'b1, 0, MD - 1);
        req = 4'b0100;
        wait_ack(a, at);
        chk("write_ack", int'(a), 4'b0100);
        chk("write_data", int'(rsp_data), 0);
        chk("write_err", int'(rsp_err), 0);
        req = '0;
        req_we = '0;

        // Range screening around MAZE_DIM
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b0, tr[k], tc[k]);
            req = 4'b0001;
            wait_ack(a, at);
            chk("range_ack", int'(a), 4'b0001);
            chk("range_err", int'(rsp_err), te[k]);
            chk("range_data", int'(rsp_data), td[k]);
            req = '0;
        end

        // Request dropped and fields changed after grant
        set_req(3, 1'b0, 10, 14);
        req  = 4'b1000;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        if (!seen) chk("drop_grant_timeout", 0, 1);
        req = '0;
        set_req(3, 1'b1, 60, 60);
        wait_ack(a, at);
        chk("drop_ack", int'(a), 4'b1000);
        chk("drop_data", int'(rsp_data), 1);
        chk("drop_err", int'(rsp_err), 0);

        // Reset during ISSUE abandons the access
        set_req(1, 1'b0, 4, 5);
        req  = 4'b0010;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = maze_oe;
        end
        if (!seen) chk("issue_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_oe", int'(maze_oe), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_row", int'(row), 0);
        rst   = 1'b0;
        start = cyc;
        wait_ack(a, at);
        chk("regrant_ack", int'(a), 4'b0010);
        chk("regrant_latency", at - start, 2);
        chk("regrant_data", int'(rsp_data), 1);
        req = '0;

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
